seq_multiplier: RTL and testbench

Parametrised sequential shift-add multiplier with selectable signed/unsigned mode, a start/busy/finished handshake and registered result hold. Processes one multiplier bit per clock, then spends one correction cycle applying the sign. Sits beside the arithmetic datapath as a multi-cycle functional unit and produces a full 2*BITS-bit product.

---
 rtl/seq_multiplier.sv | 83 ++++++++
 tb/tb_seq_multiplier.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier with signed/unsigned mode and start/busy/finished handshake; optional SEQ_MULTIPLIER_EARLY_EXIT_EN
module seq_multiplier #(
  parameter int BITS = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_signed,
  input  logic [BITS-1:0]   i_multiplicand,
  input  logic [BITS-1:0]   i_multiplier,
  output logic              o_busy,
  output logic              o_finished,
  output logic [2*BITS-1:0] o_product
);
  localparam int CW = $clog2(BITS + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state_q, state_d;
  logic [2*BITS-1:0] mcand_q, mcand_d, acc_q, acc_d, product_q, product_d;
  logic [BITS-1:0] mplier_q, mplier_d, a_mag, b_mag;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, fin_q, fin_d, last;
  assign a_mag = (i_signed & i_multiplicand[BITS-1]) ? -i_multiplicand : i_multiplicand;
  assign b_mag = (i_signed & i_multiplier[BITS-1]) ? -i_multiplier : i_multiplier;
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
  assign last = (cnt_q == CW'(1)) | (mplier_q[BITS-1:1] == '0);
`else
  assign last = cnt_q == CW'(1);
`endif
  // next-state: accept in IDLE, one multiplier bit per RUN cycle, sign correction in FIX
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    fin_d     = 1'b0;
    if (state_q == IDLE && i_start) begin
      state_d  = RUN;
      mcand_d  = {{BITS{1'b0}}, a_mag};
      mplier_d = b_mag;
      acc_d    = '0;
      cnt_d    = CW'(BITS);
      neg_d    = i_signed & (i_multiplicand[BITS-1] ^ i_multiplier[BITS-1]);
    end else if (state_q == RUN) begin
      acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      state_d  = last ? FIX : RUN;
    end else if (state_q == FIX) begin
      product_d = neg_q ? -acc_q : acc_q;
      fin_d     = 1'b1;
      state_d   = IDLE;
    end
  end
  // state registers with synchronous reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      fin_q     <= fin_d;
    end
  end
  assign o_busy     = state_q != IDLE;
  assign o_finished = fin_q;
  assign o_product  = product_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed table plus randomized sweep of seq_multiplier against an arithmetic reference
module tb_seq_multiplier;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst8 = 1'b1, st8 = 1'b0, s8 = 1'b0, busy8, fin8;
  logic [7:0] a8 = '0, b8 = '0;
  logic [15:0] p8;
  logic rst16 = 1'b1, st16 = 1'b0, s16 = 1'b0, busy16, fin16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] p16;
  int checks = 0, errors = 0;
  seq_multiplier #(.BITS(8)) dut8 (
    .i_clock(clk), .i_reset(rst8), .i_start(st8), .i_signed(s8),
    .i_multiplicand(a8), .i_multiplier(b8),
    .o_busy(busy8), .o_finished(fin8), .o_product(p8)
  );
  seq_multiplier #(.BITS(16)) dut16 (
    .i_clock(clk), .i_reset(rst16), .i_start(st16), .i_signed(s16),
    .i_multiplicand(a16), .i_multiplier(b16),
    .o_busy(busy16), .o_finished(fin16), .o_product(p16)
  );
  typedef struct {
    bit s;
    logic [7:0] a, b;
    logic [15:0] p;
  } vec_t;
  vec_t tv[7];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] a, input logic [31:0] b, input int w);
    longint sa = longint'(a), sb = longint'(b), r;
    if (s && a[w-1]) sa -= longint'(1) << w;
    if (s && b[w-1]) sb -= longint'(1) << w;
    r = sa * sb;
    return (64'(r)) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction
  function automatic int exp_lat(input bit s, input logic [31:0] b, input int w);
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
    longint mag = (s && b[w-1]) ? (longint'(1) << w) - longint'(b) : longint'(b);
    int hb = 0;
    for (int i = 0; i < w; i++) if (mag[i]) hb = i;
    return hb + 2;
`else
    return w + 1;
`endif
  endfunction
  task automatic wait8(input int start_lat, output int lat);
    lat = start_lat;
    while (!fin8 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic run8(input bit s, input logic [7:0] a, input logic [7:0] b, output int lat);
    s8 = s; a8 = a; b8 = b; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
    wait8(0, lat);
  endtask
  task automatic run16(input bit s, input logic [15:0] a, input logic [15:0] b, output int lat);
    s16 = s; a16 = a; b16 = b; st16 = 1'b1;
    @(posedge clk); #1;
    st16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom);
    lat = 0;
    while (!fin16 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask
  initial begin
    int lat, pulses;
    logic [15:0] held;
    tv[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    tv[1] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    tv[2] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    tv[3] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
    tv[4] = '{1'b0, 8'h37, 8'h01, 16'h0037};
    tv[5] = '{1'b0, 8'h37, 8'h00, 16'h0000};
    tv[6] = '{1'b0, 8'h37, 8'h80, 16'h1B80};
    repeat (2) @(posedge clk);
    #1;
    rst8 = 1'b0; rst16 = 1'b0;
    chk("reset_busy", 64'(busy8), 64'd0);
    chk("reset_fin", 64'(fin8), 64'd0);
    chk("reset_prod", 64'(p8), 64'd0);
    for (int i = 0; i < 7; i++) begin
      run8(tv[i].s, tv[i].a, tv[i].b, lat);
      chk($sformatf("vec%0d_prod", i), 64'(p8), 64'(tv[i].p));
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(exp_lat(tv[i].s, 32'(tv[i].b), 8)));
      held = p8;
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_hold", i), 64'(p8), 64'(held));
      chk($sformatf("vec%0d_fin_low", i), 64'(fin8), 64'd0);
      chk($sformatf("vec%0d_idle", i), 64'(busy8), 64'd0);
    end
    run8(1'b0, 8'd3, 8'd4, lat);
    chk("b2b_first", 64'(p8), 64'h000C);
    chk("b2b_first_busy", 64'(busy8), 64'd0);
    s8 = 1'b0; a8 = 8'd12; b8 = 8'd10; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    chk("b2b_accepted", 64'(busy8), 64'd1);
    chk("b2b_prod_kept", 64'(p8), 64'h000C);
    a8 = 8'd1; b8 = 8'd1; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    wait8(1, lat);
    chk("b2b_second", 64'(p8), 64'h0078);
    chk("b2b_second_lat", 64'(lat), 64'(exp_lat(1'b0, 32'd10, 8)));
    s8 = 1'b0; a8 = 8'h55; b8 = 8'h33; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst8 = 1'b1; st8 = 1'b1; a8 = 8'h11; b8 = 8'h11;
    @(posedge clk); #1;
    rst8 = 1'b0; st8 = 1'b0;
    chk("rst_mid_busy", 64'(busy8), 64'd0);
    chk("rst_mid_prod", 64'(p8), 64'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      pulses += int'(fin8) + int'(busy8);
      @(posedge clk); #1;
    end
    chk("rst_no_activity", 64'(pulses), 64'd0);
    chk("rst_prod_stays", 64'(p8), 64'd0);
    run16(1'b1, 16'h0000, 16'h8001, lat);
    chk("zero_a", 64'(p16), 64'd0);
    chk("zero_a_lat", 64'(lat), 64'(exp_lat(1'b1, 32'h8001, 16)));
    run16(1'b1, 16'hFFFF, 16'h0000, lat);
    chk("zero_b", 64'(p16), 64'd0);
    chk("zero_b_lat", 64'(lat), 64'(exp_lat(1'b1, 32'h0, 16)));
    for (int i = 0; i < 2000; i++) begin
      bit s;
      logic [15:0] a, b;
      s = 1'($urandom);
      a = 16'($urandom);
      b = (i % 4 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      run16(s, a, b, lat);
      chk($sformatf("rnd%0d_prod s=%0d a=%h b=%h", i, s, a, b), 64'(p16), ref_mul(s, 32'(a), 32'(b), 16));
      chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(exp_lat(s, 32'(b), 16)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
